// File: rtl/sysid_verifier_pkg.sv
// sysid_verifier_pkg
//   Shared types and constants for the system-ID verifier:
//   - state_t      : verifier FSM states
//   - FC_*         : fail_code encodings ({ts_bad, id_bad})
//   - SID_ADDR_*   : word addresses on the system-ID slave
//   - encode_fail  : maps the two mismatch flags onto a fail_code
package sysid_verifier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_ID  = 3'd1,
        ST_RD_TS  = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_ID   = 2'b01;
    localparam logic [1:0] FC_TS   = 2'b10;
    localparam logic [1:0] FC_BOTH = 2'b11;

    localparam logic SID_ADDR_ID = 1'b0;
    localparam logic SID_ADDR_TS = 1'b1;

    localparam int unsigned WAIT_W  = 4;
    localparam int unsigned RETRY_W = 4;

    function automatic logic [1:0] encode_fail(input logic id_bad, input logic ts_bad);
        logic [1:0] code;
        case ({ts_bad, id_bad})
            2'b00:   code = FC_NONE;
            2'b01:   code = FC_ID;
            2'b10:   code = FC_TS;
            default: code = FC_BOTH;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sysid_wait_timer.sv
// sysid_wait_timer
//   Loadable down-counter with a zero flag. Used to let sid_readdata settle
//   after every address change before it is sampled.
//   Ports:
//     clock       in   system clock
//     reset_n     in   synchronous active-low reset (clears the count)
//     load        in   load load_value (has priority over dec)
//     load_value  in   reload value
//     dec         in   decrement by one; holds at zero
//     zero        out  count is zero
module sysid_wait_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sysid_verifier.sv
// sysid_verifier
//   Boot-time controller: reads the system-ID word (address 0) and the build
//   timestamp word (address 1) from the system-ID slave, compares them with
//   build-time values, retries on mismatch and latches a pass/fail status that
//   gates the camera-control logic.
//   Ports:
//     clock         in   system clock
//     reset_n       in   synchronous active-low reset
//     start         in   run request, sampled only in IDLE
//     sid_readdata  in   slave read data (combinational from sid_address)
//     sid_address   out  registered slave address
//     busy          out  high from run acceptance until FINISH is left
//     done          out  one-cycle pulse at run completion
//     pass          out  latched result of the last completed run
//     fail_code     out  latched {ts_bad, id_bad}
//     retries       out  retry passes used in the last/current run
//     id_value      out  last captured ID word
//     ts_value      out  last captured timestamp word
module sysid_verifier
    import sysid_verifier_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS = 32'h518A_B941,
    parameter bit          CHECK_TS    = 1'b1,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MAX_RETRIES = 3,
    parameter bit          AUTO_START  = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] sid_readdata,
    output logic        sid_address,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [3:0]  retries,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(WAIT_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    state_t state;

    // Set by reset, cleared by the first non-reset edge: marks the single
    // cycle in which AUTO_START may launch a run without a start request.
    logic   first_cycle;

    logic   accept;
    logic   id_bad;
    logic   ts_bad;
    logic   retry_ok;
    logic   timer_load;
    logic   timer_dec;
    logic   timer_zero;

    sysid_wait_timer #(
        .WIDTH (WAIT_W)
    ) u_wait_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (WAIT_LOAD),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    // Comparison works on the captured registers, so CHECK sees the words
    // exactly as latched at the end of RD_ID / RD_TS.
    always_comb begin
        accept     = start | (AUTO_START & first_cycle);
        id_bad     = (id_value != EXPECTED_ID);
        ts_bad     = CHECK_TS && (ts_value != EXPECTED_TS);
        retry_ok   = (id_bad | ts_bad) && (retries < RETRY_MAX);
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                timer_load = accept;
            end
            ST_RD_ID, ST_RD_TS: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_CHECK: begin
                timer_load = retry_ok;
            end
            default: begin
                timer_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            first_cycle <= 1'b1;
            sid_address <= SID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FC_NONE;
            retries     <= '0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            first_cycle <= 1'b0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_RD_ID;
                        sid_address <= SID_ADDR_ID;
                        busy        <= 1'b1;
                        pass        <= 1'b0;
                        fail_code   <= FC_NONE;
                        retries     <= '0;
                    end
                end
                ST_RD_ID: begin
                    if (timer_zero) begin
                        id_value    <= sid_readdata;
                        sid_address <= SID_ADDR_TS;
                        state       <= ST_RD_TS;
                    end
                end
                ST_RD_TS: begin
                    if (timer_zero) begin
                        ts_value <= sid_readdata;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (retry_ok) begin
                        retries     <= retries + 4'd1;
                        sid_address <= SID_ADDR_ID;
                        state       <= ST_RD_ID;
                    end else begin
                        pass      <= !(id_bad | ts_bad);
                        fail_code <= encode_fail(id_bad, ts_bad);
                        state     <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    sid_address <= SID_ADDR_ID;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_verifier.sv
module tb_sysid_verifier;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;
    logic rst_c;

    int vectors     = 0;
    int miscompares = 0;
    int edges       = 0;
    int acc         = 0;
    int seen_done   = 0;

    // Instance A: defaults (CHECK_TS=1, MAX_RETRIES=3, AUTO_START=0)
    logic        start_a;
    logic [31:0] id_a, ts_a, rd_a;
    logic        addr_a, busy_a, done_a, pass_a;
    logic [1:0]  fc_a;
    logic [3:0]  ret_a;
    logic [31:0] idv_a, tsv_a;
    assign rd_a = addr_a ? ts_a : id_a;

    // Instance B: CHECK_TS=0
    logic        start_b;
    logic [31:0] id_b, ts_b, rd_b;
    logic        addr_b, busy_b, done_b, pass_b;
    logic [1:0]  fc_b;
    logic [3:0]  ret_b;
    logic [31:0] idv_b, tsv_b;
    assign rd_b = addr_b ? ts_b : id_b;

    // Instance C: AUTO_START=1, own reset
    logic        start_c;
    logic [31:0] rd_c;
    logic        addr_c, busy_c, done_c, pass_c;
    logic [1:0]  fc_c;
    logic [3:0]  ret_c;
    logic [31:0] idv_c, tsv_c;
    assign rd_c = addr_c ? 32'h518A_B941 : 32'h0000_0000;

    sysid_verifier #(
        .WAIT_CYCLES (1),
        .MAX_RETRIES (3),
        .CHECK_TS    (1'b1),
        .AUTO_START  (1'b0)
    ) dut_a (
        .clock (clock), .reset_n (reset_n), .start (start_a), .sid_readdata (rd_a),
        .sid_address (addr_a), .busy (busy_a), .done (done_a), .pass (pass_a),
        .fail_code (fc_a), .retries (ret_a), .id_value (idv_a), .ts_value (tsv_a)
    );

    sysid_verifier #(
        .WAIT_CYCLES (1),
        .MAX_RETRIES (3),
        .CHECK_TS    (1'b0),
        .AUTO_START  (1'b0)
    ) dut_b (
        .clock (clock), .reset_n (reset_n), .start (start_b), .sid_readdata (rd_b),
        .sid_address (addr_b), .busy (busy_b), .done (done_b), .pass (pass_b),
        .fail_code (fc_b), .retries (ret_b), .id_value (idv_b), .ts_value (tsv_b)
    );

    sysid_verifier #(
        .WAIT_CYCLES (1),
        .MAX_RETRIES (3),
        .CHECK_TS    (1'b1),
        .AUTO_START  (1'b1)
    ) dut_c (
        .clock (clock), .reset_n (rst_c), .start (start_c), .sid_readdata (rd_c),
        .sid_address (addr_c), .busy (busy_c), .done (done_c), .pass (pass_c),
        .fail_code (fc_c), .retries (ret_c), .id_value (idv_c), .ts_value (tsv_c)
    );

    task automatic tick();
        @(posedge clock);
        #1;
        edges++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    // Bounded wait for a done pulse; an expired budget shows up as a wrong
    // edge count in the caller's check.
    task automatic wait_done(input int which, input int budget);
        int n = 0;
        while (!done_of(which) && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        acc = edges;
    endtask

    initial begin
        reset_n = 1'b0;
        rst_c   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        id_a    = 32'h0;
        ts_a    = 32'h518A_B941;
        id_b    = 32'h0;
        ts_b    = 32'h518A_B940;
        repeat (3) tick();

        // Reset state
        chk("rst_busy",  {31'd0, busy_a}, 32'd0);
        chk("rst_done",  {31'd0, done_a}, 32'd0);
        chk("rst_pass",  {31'd0, pass_a}, 32'd0);
        chk("rst_fc",    {30'd0, fc_a},   32'd0);
        chk("rst_ret",   {28'd0, ret_a},  32'd0);
        chk("rst_addr",  {31'd0, addr_a}, 32'd0);
        chk("rst_idv",   idv_a,           32'd0);
        chk("rst_tsv",   tsv_a,           32'd0);

        reset_n = 1'b1;
        tick();

        // Passing first attempt
        pulse_start_a();
        chk("t1_busy", {31'd0, busy_a}, 32'd1);
        chk("t1_addr0", {31'd0, addr_a}, 32'd0);
        tick();
        tick();
        chk("t1_addr1", {31'd0, addr_a}, 32'd1);
        wait_done(0, 60);
        chk("t1_latency", edges - acc, 32'd6);
        chk("t1_pass",  {31'd0, pass_a}, 32'd1);
        chk("t1_fc",    {30'd0, fc_a},   32'd0);
        chk("t1_ret",   {28'd0, ret_a},  32'd0);
        chk("t1_idv",   idv_a,           32'h0000_0000);
        chk("t1_tsv",   tsv_a,           32'h518A_B941);
        chk("t1_busy0", {31'd0, busy_a}, 32'd0);
        chk("t1_addr_fin", {31'd0, addr_a}, 32'd0);
        tick();
        chk("t1_done_pulse", {31'd0, done_a}, 32'd0);
        chk("t1_pass_hold", {31'd0, pass_a}, 32'd1);

        // Timestamp mismatch, retries exhausted
        ts_a = 32'h518A_B940;
        pulse_start_a();
        chk("t2_pass_clr", {31'd0, pass_a}, 32'd0);
        wait_done(0, 60);
        chk("t2_latency", edges - acc, 32'd21);
        chk("t2_pass",  {31'd0, pass_a}, 32'd0);
        chk("t2_fc",    {30'd0, fc_a},   32'd2);
        chk("t2_ret",   {28'd0, ret_a},  32'd3);
        chk("t2_tsv",   tsv_a,           32'h518A_B940);
        ts_a = 32'h518A_B941;

        // CHECK_TS=0: wrong timestamp captured but does not fail
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        acc = edges;
        wait_done(1, 60);
        chk("t2b_latency", edges - acc, 32'd6);
        chk("t2b_pass", {31'd0, pass_b}, 32'd1);
        chk("t2b_fc",   {30'd0, fc_b},   32'd0);
        chk("t2b_ret",  {28'd0, ret_b},  32'd0);
        chk("t2b_tsv",  tsv_b,           32'h518A_B940);
        tick();

        // Bad ID on first pass only
        id_a = 32'h0000_0001;
        pulse_start_a();
        tick();
        tick();
        chk("t3_idv_bad", idv_a, 32'h0000_0001);
        id_a = 32'h0;
        wait_done(0, 60);
        chk("t3_latency", edges - acc, 32'd11);
        chk("t3_pass", {31'd0, pass_a}, 32'd1);
        chk("t3_ret",  {28'd0, ret_a},  32'd1);
        chk("t3_fc",   {30'd0, fc_a},   32'd0);
        chk("t3_idv",  idv_a,           32'h0);
        tick();

        // start held through the run and during FINISH
        start_a = 1'b1;
        tick();
        acc = edges;
        repeat (5) begin
            tick();
            chk("t4_busy_run", {31'd0, busy_a}, 32'd1);
        end
        tick();
        start_a = 1'b0;
        chk("t4_done", {31'd0, done_a}, 32'd1);
        chk("t4_latency", edges - acc, 32'd6);
        seen_done = 0;
        repeat (4) begin
            tick();
            if (done_a || busy_a) seen_done++;
        end
        chk("t4_no_rerun", seen_done, 32'd0);

        // Reset during RD_TS
        pulse_start_a();
        repeat (3) tick();
        chk("t5_in_rdts", {31'd0, addr_a}, 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t5_busy", {31'd0, busy_a}, 32'd0);
        chk("t5_addr", {31'd0, addr_a}, 32'd0);
        chk("t5_pass", {31'd0, pass_a}, 32'd0);
        chk("t5_ret",  {28'd0, ret_a},  32'd0);
        chk("t5_tsv",  tsv_a,           32'd0);
        chk("t5_idv",  idv_a,           32'd0);
        seen_done = 0;
        repeat (10) begin
            tick();
            if (done_a || busy_a) seen_done++;
        end
        chk("t5_stay_idle", seen_done, 32'd0);

        // AUTO_START
        chk("t6_pre_busy", {31'd0, busy_c}, 32'd0);
        rst_c = 1'b1;
        tick();
        chk("t6_busy", {31'd0, busy_c}, 32'd1);
        repeat (6) tick();
        chk("t6_pass", {31'd0, pass_c}, 32'd1);
        chk("t6_done", {31'd0, done_c}, 32'd1);
        chk("t6_tsv",  tsv_c,           32'h518A_B941);
        repeat (3) tick();
        chk("t6_idle", {31'd0, busy_c}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sysid_verifier.md
Name: sysid_verifier

Overview:
- Boot-time controller that sequences reads of the system-ID slave: reads address 0 (system ID word), then address 1 (build timestamp word).
- Compares both words against build-time expected values and retries on mismatch.
- Publishes a latched pass/fail status so the camera-control logic stays gated until the hardware image is confirmed.
- Sits between the system-ID slave's control port and the camera enable logic; it is the only master of that slave.

Parameters:
- EXPECTED_ID, 32'h00000000, expected word at address 0.
- EXPECTED_TS, 32'h518AB941, expected word at address 1.
- CHECK_TS, 1, 1 = the timestamp must match; 0 = the timestamp is captured but never fails the check.
- WAIT_CYCLES, 1, settle cycles after an address change before readdata is sampled; range 0..15.
- MAX_RETRIES, 3, re-read passes allowed after the first failed check; range 0..15.
- AUTO_START, 0, 1 = a run starts automatically in the first cycle after reset deasserts.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- sid_readdata  in  32  read data from the system-ID slave; combinational from sid_address.
- sid_address  out  1  registered address driven to the system-ID slave.
- busy  out  1  high from run acceptance until the FINISH state is left.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  latched result of the last completed run.
- fail_code  out  2  latched: 00 none, 01 ID mismatch, 10 TS mismatch, 11 both.
- retries  out  4  number of retry passes used in the last or current run.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low, sampled on the rising edge of clock. The clock and reset ports are named clock and reset_n.
- Reset values: every output is 0; the FSM is in IDLE; wait and retry counters are 0.
- FSM states: IDLE, RD_ID, RD_TS, CHECK, FINISH.
- IDLE: when start=1 (or, with AUTO_START=1, in the first post-reset cycle), go to RD_ID. In the same edge: sid_address<=0, wait counter<=WAIT_CYCLES, busy<=1, pass<=0, fail_code<=0, retries<=0.
- RD_ID: decrement the wait counter each cycle. In the cycle where the counter is 0: capture sid_readdata into id_value, set sid_address<=1, reload the counter, go to RD_TS. The state lasts WAIT_CYCLES+1 cycles.
- RD_TS: same counting. When the counter is 0: capture ts_value, go to CHECK. The state lasts WAIT_CYCLES+1 cycles.
- CHECK (1 cycle): id_bad = id_value != EXPECTED_ID; ts_bad = CHECK_TS && ts_value != EXPECTED_TS.
  - If either is bad and retries < MAX_RETRIES: retries+1, sid_address<=0, reload the counter, go to RD_ID.
  - Otherwise: pass <= !(id_bad|ts_bad), fail_code <= {ts_bad,id_bad}, go to FINISH.
- FINISH (1 cycle): done=1, busy=0 as a registered output, sid_address<=0, go to IDLE.
- Latency: for a passing first attempt, done is asserted 2*WAIT_CYCLES+4 edges after the edge that accepts start. Each retry adds 2*WAIT_CYCLES+3 cycles.
- start while busy, or asserted during FINISH, is ignored; no queuing. Holding start high continuously restarts the run once per IDLE visit.
- pass, fail_code, id_value and ts_value hold until the next run is accepted. pass and fail_code clear at acceptance; id_value and ts_value are overwritten at capture.
- With MAX_RETRIES=0, a failed check goes straight to FINISH.
- retries saturates at MAX_RETRIES and never wraps.
- Reset mid-run: the next edge returns everything to reset values; no done pulse is produced.

Decomposition:
- Package sysid_verifier_pkg holds:
  - the state enum;
  - fail_code encodings FC_NONE, FC_ID, FC_TS, FC_BOTH;
  - address constants SID_ADDR_ID=0 and SID_ADDR_TS=1.
- Sub-module sysid_wait_timer: loadable down-counter with a zero flag, shared by RD_ID and RD_TS.

Test Plan:
- The bench model returns readdata = address ? 32'h518AB941 : 0, with WAIT_CYCLES=1.
- Reset, then a 1-cycle start -> busy=1 at the next cycle; done pulses 6 edges after acceptance; pass=1, fail_code=00, retries=0, id_value=0, ts_value=32'h518AB941.
- Model timestamp forced to 32'h518AB940, MAX_RETRIES=3 -> 4 read passes; pass=0, fail_code=10, retries=3. With CHECK_TS=0 -> pass=1.
- Model ID = 32'h00000001 on the first pass only -> pass=1, retries=1, done 11 edges after acceptance.
- start held high throughout a run, then pulsed in the FINISH cycle -> exactly one run completes before IDLE; the FINISH pulse does not trigger a second run.
- reset_n low for 1 cycle during RD_TS -> all outputs 0 at the next edge; no done pulse; the FSM stays in IDLE.
- AUTO_START=1 -> busy rises in the cycle after reset deasserts without start; pass=1 after 6 more edges.
